// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Package   : lsu_defs
// Purpose   : Access-size encodings, FSM state encoding and alignment helper
//             shared by the load/store unit.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_defs;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Reserved size 3 is checked like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = |lo;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module    : lsu_align
// Purpose   : Little-endian lane extract/extend for loads and lane merge for
//             read-modify-write stores. Purely combinational.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_defs::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    w_byte      = i_word[{i_lane, 3'b000} +: 8];
    w_half      = i_lane[1] ? i_word[31:16] : i_word[15:0];
    w_sign      = 1'b0;
    o_load_data = i_word;
    o_merged    = i_word;
    case (i_size)
      SZ_BYTE: begin
        w_sign                          = ~i_unsigned & w_byte[7];
        o_load_data                     = {{24{w_sign}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        // addr[0] is ignored here, which is what forces halves to natural alignment
        w_sign                             = ~i_unsigned & w_half[15];
        o_load_data                        = {{16{w_sign}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load_data = i_word;
        o_merged    = i_wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module    : load_store_unit
// Purpose   : Data-memory initiator: byte/half/word loads and stores, with
//             read-modify-write for sub-word stores. Optional macro
//             LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  logic [1:0]        r_addr_lo;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_misalign;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  lsu_align u_align (
    .i_size      (r_size),
    .i_lane      (r_addr_lo),
    .i_unsigned  (r_unsigned),
    .i_word      (mem_rdata),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr_lo    <= 2'b00;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr_lo    <= req_addr[1:0];
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_write      <= req_write;
            r_wdata      <= req_wdata;
            r_mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            if (w_misalign) begin
              r_resp_err <= 1'b1;
              r_state    <= S_RESP;
            end else if (req_write && req_size[1]) begin
              // Whole-word store needs no read of the old word
              r_mem_wdata <= req_wdata;
              r_mem_write <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= S_RD;
            end
          end
        end
        S_RD: begin
          r_mem_read <= 1'b0;
          if (r_write) begin
            r_mem_wdata <= w_merged;
            r_mem_write <= 1'b1;
            r_state     <= S_WR;
          end else begin
            r_resp_rdata <= w_load_data;
            r_state      <= S_RESP;
          end
        end
        S_WR: begin
          r_mem_write <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // Strobes drop the instant reset rises, even mid-transaction
  assign mem_read   = r_mem_read  & ~reset;
  assign mem_write  = r_mem_write & ~reset;

endmodule

`default_nettype wire
